countdown_timer: RTL and testbench

Loadable down-counter. It is the counterpart to the team's saturating up-counter. It counts from a loaded start value down to EndVal, then flags expiry. It sits in the timer/watchdog path: software-side logic loads a period through a valid/ready handshake and starts it, and the block reports busy, a one-cycle done pulse and a sticky expired flag. Built together with a formal harness (SBY, abc pdr) in the same style as the counter checks.

---
 rtl/countdown_timer.sv | 123 ++++++++++++
 tb/tb_countdown_timer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// Loadable down-counter from a start value to EndVal with done pulse and sticky expiry; optional auto-reload.
// Outputs are registered, one cycle after the deciding edge; LoadReady_o is low (loads refused) while counting.
module countdown_timer #(
   parameter int Width      = 32,
   parameter int InitVal    = 64,
   parameter int EndVal     = 8,
   parameter int AutoReload = 0
) (
   input  logic             Clk_i,
   input  logic             Reset_n_i,
   input  logic             LoadValid_i,
   input  logic [Width-1:0] LoadData_i,
   output logic             LoadReady_o,
   input  logic             Start_i,
   input  logic             Pause_i,
   output logic [Width-1:0] Data_o,
   output logic             Busy_o,
   output logic             Done_o,
   output logic             Expired_o
);

   localparam logic [Width-1:0] INIT_V = Width'(InitVal);
   localparam logic [Width-1:0] END_V  = Width'(EndVal);

   if ((EndVal > InitVal) || ((Width < 32) && ((InitVal >> Width) != 0))) begin : g_bad_params
      $error("countdown_timer: need EndVal <= InitVal < 2**Width");
   end

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [Width-1:0] data_q;
   logic [Width-1:0] reload_q;
   logic             ready_q;
   logic             busy_q;
   logic             done_q;
   logic             expired_q;
   logic [Width-1:0] load_v;
   logic             load_acc;

   // Loads below the terminal value are clamped so the count can never underflow.
   assign load_v   = (LoadData_i < END_V) ? END_V : LoadData_i;
   assign load_acc = LoadValid_i && ready_q;

   always_ff @(posedge Clk_i or negedge Reset_n_i) begin
      if (!Reset_n_i) begin
         state     <= IDLE;
         data_q    <= INIT_V;
         reload_q  <= INIT_V;
         ready_q   <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         expired_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (load_acc) begin
                  data_q   <= load_v;
                  reload_q <= load_v;
               end else if (Start_i) begin
                  if (data_q > END_V) begin
                     state     <= RUN;
                     ready_q   <= 1'b0;
                     busy_q    <= 1'b1;
                     expired_q <= 1'b0;
                  end else begin
                     state     <= DONE;
                     done_q    <= 1'b1;
                     expired_q <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (!Pause_i) begin
                  if (data_q == END_V + 1'b1) begin
                     state     <= DONE;
                     data_q    <= END_V;
                     ready_q   <= 1'b1;
                     busy_q    <= 1'b0;
                     done_q    <= 1'b1;
                     expired_q <= 1'b1;
                  end else begin
                     data_q <= data_q - 1'b1;
                  end
               end
            end
            DONE: begin
               if (load_acc) begin
                  state     <= IDLE;
                  data_q    <= load_v;
                  reload_q  <= load_v;
                  expired_q <= 1'b0;
               end else if (Start_i || (AutoReload != 0)) begin
                  // A reload equal to EndVal expires again without ever entering RUN.
                  data_q <= reload_q;
                  if (reload_q > END_V) begin
                     state     <= RUN;
                     ready_q   <= 1'b0;
                     busy_q    <= 1'b1;
                     expired_q <= 1'b0;
                  end else begin
                     done_q    <= 1'b1;
                     expired_q <= 1'b1;
                  end
               end
            end
            default: begin
               state   <= IDLE;
               ready_q <= 1'b1;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign Data_o      = data_q;
   assign LoadReady_o = ready_q;
   assign Busy_o      = busy_q;
   assign Done_o      = done_q;
   assign Expired_o   = expired_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: a vector table plus hand sequences for countdown, pause, auto-reload and async reset.
module tb_countdown_timer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        load_vld = 1'b0;
   logic [31:0] load_dat = '0;
   logic        start = 1'b0;
   logic        pause = 1'b0;

   logic [31:0] d0_data, d1_data;
   logic        d0_rdy, d0_busy, d0_done, d0_exp;
   logic        d1_rdy, d1_busy, d1_done, d1_exp;

   int checks = 0;
   int errs   = 0;

   always #5 clk = ~clk;

   countdown_timer #(.Width(32), .InitVal(64), .EndVal(8), .AutoReload(0)) dut0 (
      .Clk_i(clk), .Reset_n_i(rst_n), .LoadValid_i(load_vld), .LoadData_i(load_dat),
      .LoadReady_o(d0_rdy), .Start_i(start), .Pause_i(pause), .Data_o(d0_data),
      .Busy_o(d0_busy), .Done_o(d0_done), .Expired_o(d0_exp)
   );

   countdown_timer #(.Width(32), .InitVal(64), .EndVal(8), .AutoReload(1)) dut1 (
      .Clk_i(clk), .Reset_n_i(rst_n), .LoadValid_i(load_vld), .LoadData_i(load_dat),
      .LoadReady_o(d1_rdy), .Start_i(start), .Pause_i(pause), .Data_o(d1_data),
      .Busy_o(d1_busy), .Done_o(d1_done), .Expired_o(d1_exp)
   );

   typedef struct {
      bit          rst_before;
      bit          lv;
      logic [31:0] ld;
      bit          st;
      bit          pa;
      logic [31:0] e_data;
      bit          e_rdy;
      bit          e_busy;
      bit          e_done;
      bit          e_exp;
   } vec_t;

   vec_t vq[$];

   task automatic add(input bit rb, input bit lv, input int ld, input bit st, input bit pa,
                      input int ed, input bit er, input bit eb, input bit edn, input bit eex);
      vec_t v;
      v.rst_before = rb; v.lv = lv; v.ld = ld; v.st = st; v.pa = pa;
      v.e_data = ed; v.e_rdy = er; v.e_busy = eb; v.e_done = edn; v.e_exp = eex;
      vq.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_all(input string name, input logic [31:0] ed, input bit er, input bit eb,
                          input bit edn, input bit eex);
      chk({name, ".data"}, d0_data, ed);
      chk({name, ".ready"}, {31'd0, d0_rdy}, {31'd0, er});
      chk({name, ".busy"}, {31'd0, d0_busy}, {31'd0, eb});
      chk({name, ".done"}, {31'd0, d0_done}, {31'd0, edn});
      chk({name, ".expired"}, {31'd0, d0_exp}, {31'd0, eex});
   endtask

   task automatic do_reset();
      rst_n = 1'b0; load_vld = 1'b0; load_dat = '0; start = 1'b0; pause = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit lv, input int ld, input bit st, input bit pa);
      load_vld = lv; load_dat = ld; start = st; pause = pa;
   endtask

   initial begin
      int dones;
      int ph;
      logic [31:0] exp_d;

      // Load/start precedence in IDLE, loads ignored in RUN, pause.
      add(1, 1, 20, 1, 0, 20, 1, 0, 0, 0);
      add(0, 0,  0, 0, 0, 20, 1, 0, 0, 0);
      add(0, 0,  0, 1, 0, 20, 0, 1, 0, 0);
      add(0, 1,  5, 0, 0, 19, 0, 1, 0, 0);
      add(0, 1, 50, 1, 0, 18, 0, 1, 0, 0);
      add(0, 0,  0, 0, 1, 18, 0, 1, 0, 0);
      add(0, 1,  9, 0, 1, 18, 0, 1, 0, 0);
      add(0, 0,  0, 0, 0, 17, 0, 1, 0, 0);
      // Clamped load, immediate expiry, restart from DONE.
      add(1, 1,  3, 0, 0,  8, 1, 0, 0, 0);
      add(0, 0,  0, 1, 0,  8, 1, 0, 1, 1);
      add(0, 0,  0, 0, 0,  8, 1, 0, 0, 1);
      add(0, 0,  0, 1, 0,  8, 1, 0, 1, 1);
      add(0, 0,  0, 0, 0,  8, 1, 0, 0, 1);
      add(0, 1,  9, 0, 0,  9, 1, 0, 0, 0);
      add(0, 0,  0, 1, 0,  9, 0, 1, 0, 0);
      add(0, 0,  0, 0, 0,  8, 1, 0, 1, 1);
      add(0, 0,  0, 0, 0,  8, 1, 0, 0, 1);
      add(0, 0,  0, 1, 0,  9, 0, 1, 0, 0);
      add(0, 0,  0, 0, 1,  9, 0, 1, 0, 0);
      add(0, 0,  0, 0, 0,  8, 1, 0, 1, 1);

      // Reset state and full default countdown.
      do_reset();
      chk_all("reset", 64, 1, 0, 0, 0);
      drive(0, 0, 1, 0);
      step();
      drive(0, 0, 0, 0);
      chk_all("t1_start", 64, 0, 1, 0, 0);
      dones = 0;
      for (int k = 1; k <= 56; k++) begin
         step();
         chk("t1_count", d0_data, 32'(64 - k));
         if (d0_done) dones++;
      end
      chk_all("t1_end", 8, 1, 0, 1, 1);
      step();
      chk_all("t1_hold", 8, 1, 0, 0, 1);
      chk("t1_pulses", dones, 1);

      // Pause while counting.
      drive(1, 12, 0, 0);
      step();
      chk_all("t2_load", 12, 1, 0, 0, 0);
      drive(0, 0, 1, 0);
      step();
      drive(0, 0, 0, 0);
      chk("t2_run", d0_data, 12);
      step(); chk("t2_11", d0_data, 11);
      step(); chk("t2_10", d0_data, 10);
      dones = 0;
      pause = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("t2_paused", d0_data, 10);
         if (d0_done) dones++;
      end
      pause = 1'b0;
      step(); chk("t2_9", d0_data, 9);
      if (d0_done) dones++;
      step(); chk_all("t2_end", 8, 1, 0, 1, 1);
      if (d0_done) dones++;
      chk("t2_pulses", dones, 1);

      // Vector table.
      foreach (vq[i]) begin
         if (vq[i].rst_before) do_reset();
         drive(vq[i].lv, int'(vq[i].ld), vq[i].st, vq[i].pa);
         step();
         drive(0, 0, 0, 0);
         chk_all($sformatf("vec%0d", i), vq[i].e_data, vq[i].e_rdy, vq[i].e_busy,
                 vq[i].e_done, vq[i].e_exp);
      end

      // Auto-reload instance: period 10..8 repeating.
      do_reset();
      drive(1, 10, 0, 0);
      step();
      drive(0, 0, 1, 0);
      step();
      drive(0, 0, 0, 0);
      chk("t5_run", d1_data, 10);
      chk("t5_busy", {31'd0, d1_busy}, 32'd1);
      for (int j = 1; j <= 8; j++) begin
         step();
         ph = j % 3;
         exp_d = (ph == 0) ? 32'd10 : (ph == 1) ? 32'd9 : 32'd8;
         chk($sformatf("t5_data%0d", j), d1_data, exp_d);
         chk($sformatf("t5_done%0d", j), {31'd0, d1_done}, (ph == 2) ? 32'd1 : 32'd0);
      end
      chk("t5_ready", {31'd0, d1_rdy}, 32'd1);
      chk("t5_expired", {31'd0, d1_exp}, 32'd1);

      // Asynchronous reset mid-run.
      do_reset();
      drive(0, 0, 1, 0);
      step();
      drive(0, 0, 0, 1);
      drive(0, 0, 0, 0);
      for (int k = 0; k < 34; k++) step();
      chk("t6_pre", d0_data, 30);
      pause = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      chk_all("t6_async", 64, 1, 0, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      pause = 1'b0;
      step();
      step();
      chk_all("t6_idle", 64, 1, 0, 0, 0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
